// File: rtl/uart_num_rx_pkg.sv
// uart_num_rx_pkg: shared types and constants for the multi-number UART receiver
// Optional UART_NUM_RX_PARITY_EN adds the PARITY byte state.
package uart_num_rx_pkg;
  typedef logic signed [15:0] num;
  localparam logic UART_IDLE = 1'b1;
  localparam int DEF_CLKS_PER_BIT = 868;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_NUM_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_e;
endpackage

// File: rtl/uart_num_rx_if.sv
// uart_num_rx_if: received-vector bus from uart_num_rx to the vector consumer
interface uart_num_rx_if import uart_num_rx_pkg::*; #(parameter int N_NUMS = 5) ();
  num [N_NUMS-1:0] rx_nums;
  logic rx_available;
  logic frame_error;
  logic busy;
  modport master(output rx_nums, rx_available, frame_error, busy);
  modport slave(input rx_nums, rx_available, frame_error, busy);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: synchronised 8N1 byte receiver (8E1 when UART_NUM_RX_PARITY_EN is defined)
module uart_byte_rx import uart_num_rx_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_error,
  output logic       active
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  // sync[1] is the synchronised line, sync[2] its previous value for edge detection
  logic [2:0] sync;
  logic line, fall, tick;
  state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  assign line = sync[1];
  assign fall = sync[2] & ~sync[1];
  assign tick = cnt == '0;
  assign byte_data = sh;
  assign active = state != S_IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= {3{UART_IDLE}};
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      sync  <= {sync[1:0], rx};
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = tick ? CW'(CLKS_PER_BIT - 1) : cnt - 1'b1;
    idx_n = idx;
    sh_n = sh;
    byte_valid = 1'b0;
    frame_error = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = CW'(CLKS_PER_BIT / 2);
        idx_n = '0;
        state_n = fall ? S_START : S_IDLE;
      end
      S_START: if (tick) state_n = line ? S_IDLE : S_DATA;
      S_DATA: if (tick) begin
        sh_n = {line, sh[7:1]};
        idx_n = idx + 1'b1;
`ifdef UART_NUM_RX_PARITY_EN
        state_n = idx == 3'd7 ? S_PARITY : S_DATA;
`else
        state_n = idx == 3'd7 ? S_STOP : S_DATA;
`endif
      end
`ifdef UART_NUM_RX_PARITY_EN
      // the stop bit that follows is high, so returning to IDLE cannot see a false edge
      S_PARITY: if (tick) begin
        frame_error = line != ^sh;
        state_n = frame_error ? S_IDLE : S_STOP;
      end
`endif
      S_STOP: if (tick) begin
        byte_valid = line;
        frame_error = ~line;
        state_n = line ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (!line) cnt_n = CW'(CLKS_PER_BIT - 1);
        else if (tick) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_num_rx.sv
// uart_num_rx: assembles UART bytes into a vector of signed 16-bit nums (MSB byte first)
// Optional UART_NUM_RX_PARITY_EN selects 8E1 framing in the byte receiver.
module uart_num_rx import uart_num_rx_pkg::*; #(
  parameter int N_NUMS       = 5,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 20
) (
  input logic clk,
  input logic reset,
  input logic rx,
  uart_num_rx_if.master bus
);
  localparam int BW = $clog2(2 * N_NUMS);
  localparam int NW = $clog2(N_NUMS);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO + 1);
  logic [7:0] byte_data;
  logic byte_valid, byte_fe, active, last, timeout;
  logic [BW-1:0] byte_cnt;
  logic [NW-1:0] num_idx;
  logic [TW-1:0] idle_cnt;
  num [N_NUMS-1:0] stage, stage_n;
  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(clk), .reset(reset), .rx(rx),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .frame_error(byte_fe), .active(active)
  );
  assign num_idx = NW'(byte_cnt >> 1);
  assign last = byte_cnt == BW'(2 * N_NUMS - 1);
  assign timeout = idle_cnt == TW'(TO - 1);
  assign bus.busy = active | (byte_cnt != '0);
  always_comb begin
    stage_n = stage;
    if (byte_valid)
      stage_n[num_idx] = byte_cnt[0] ? {stage[num_idx][15:8], byte_data} : {byte_data, stage[num_idx][7:0]};
  end
  // rx_nums only moves as a whole when the final byte lands, so consumers never see partial data
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rx_nums      <= '0;
      bus.rx_available <= 1'b0;
      bus.frame_error  <= 1'b0;
      stage            <= '0;
      byte_cnt         <= '0;
      idle_cnt         <= '0;
    end else begin
      bus.rx_available <= byte_valid & last;
      bus.frame_error  <= byte_fe;
      stage            <= stage_n;
      idle_cnt         <= (active || byte_cnt == '0) ? '0 : idle_cnt + 1'b1;
      if (byte_fe || timeout) byte_cnt <= '0;
      else if (byte_valid) byte_cnt <= last ? '0 : byte_cnt + 1'b1;
      if (byte_valid && last) bus.rx_nums <= stage_n;
    end
  end
endmodule

// File: tb/tb_uart_num_rx.sv
// tb_uart_num_rx: directed self-checking bench for uart_num_rx with CLKS_PER_BIT=16, N_NUMS=5
module tb_uart_num_rx;
  localparam int C = 16;
`ifdef UART_NUM_RX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  int checks = 0, errors = 0;
  int cyc = 0, avail_cnt = 0, fe_cnt = 0, t_last = 0, t_prev = 0;
  int a0, f0, n;
  uart_num_rx_if #(.N_NUMS(5)) bus ();
  uart_num_rx #(.N_NUMS(5), .CLKS_PER_BIT(C), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .reset(reset), .rx(rx), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (bus.rx_available === 1'b1) begin
      avail_cnt++;
      t_prev = t_last;
      t_last = cyc;
    end
    if (bus.frame_error === 1'b1) fe_cnt++;
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [79:0] vec(input logic [15:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction
  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
`ifdef UART_NUM_RX_PARITY_EN
    rx = ^b;
    repeat (C) @(negedge clk);
`endif
    rx = stop;
    repeat (C) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic send_vector(input logic [79:0] v);
    for (int i = 0; i < 5; i++) begin
      send_byte(v[16*i+8 +: 8]);
      send_byte(v[16*i +: 8]);
    end
  endtask
  initial begin
    repeat (4) @(negedge clk);
    chk("reset_nums", bus.rx_nums, 0);
    chk("reset_avail", bus.rx_available, 0);
    chk("reset_fe", bus.frame_error, 0);
    chk("reset_busy", bus.busy, 0);
    reset = 1'b0;
    idle(4);
    // basic vector
    a0 = avail_cnt; f0 = fe_cnt;
    send_vector(vec(16'hDABE, 16'h00C1, 16'hFD3C, 16'hFEDA, 16'hF6A5));
    idle(2 * C);
    chk("v1_strobes", avail_cnt - a0, 1);
    chk("v1_nums", bus.rx_nums, 80'hF6A5_FEDA_FD3C_00C1_DABE);
    chk("v1_no_fe", fe_cnt - f0, 0);
    chk("v1_busy", bus.busy, 0);
    // short low glitch on idle line
    a0 = avail_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", bus.busy, 1);
    idle(8);
    chk("glitch_busy_lo", bus.busy, 0);
    chk("glitch_no_avail", avail_cnt - a0, 0);
    chk("glitch_no_fe", fe_cnt - f0, 0);
    chk("glitch_nums", bus.rx_nums, 80'hF6A5_FEDA_FD3C_00C1_DABE);
    // bad stop bit on byte 3, then a clean vector
    a0 = avail_cnt; f0 = fe_cnt;
    send_byte(8'hDA); send_byte(8'hBE); send_byte(8'h00); send_byte(8'hC1, 1'b0);
    chk("fe_pulse", fe_cnt - f0, 1);
    chk("fe_no_avail", avail_cnt - a0, 0);
    idle(2 * C);
    send_vector(vec(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005));
    idle(2 * C);
    chk("v2_strobes", avail_cnt - a0, 1);
    chk("v2_nums", bus.rx_nums, 80'h0005_0004_0003_0002_0001);
    // partial vector dropped by timeout
    a0 = avail_cnt;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(20 * C);
    chk("timeout_busy", bus.busy, 0);
    chk("timeout_no_avail", avail_cnt - a0, 0);
    send_vector(vec(16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h1234));
    idle(2 * C);
    chk("v3_strobes", avail_cnt - a0, 1);
    chk("v3_nums", bus.rx_nums, 80'h1234_FFFF_0000_8000_7FFF);
    n = bus.rx_nums[1];
    checks++;
    assert (n == -32768) else begin
      errors++;
      $error("FAIL v3_neg: observed %0d expected %0d", n, -32768);
    end
    // reset in the middle of byte 6
    send_byte(8'h13); send_byte(8'h57); send_byte(8'h24); send_byte(8'h68); send_byte(8'h9B);
    rx = 1'b0;
    repeat (3 * C / 2) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_nums", bus.rx_nums, 0);
    chk("rst_avail", bus.rx_available, 0);
    chk("rst_fe", bus.frame_error, 0);
    chk("rst_busy", bus.busy, 0);
    a0 = avail_cnt;
    send_vector(vec(16'h1357, 16'h2468, 16'h9BDF, 16'h0F0F, 16'hF0F0));
    idle(2 * C);
    chk("v4_strobes", avail_cnt - a0, 1);
    chk("v4_nums", bus.rx_nums, 80'hF0F0_0F0F_9BDF_2468_1357);
    // two vectors with zero idle between them
    a0 = avail_cnt;
    send_vector(vec(16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hE005));
    chk("v5_nums", bus.rx_nums, 80'hE005_D004_C003_B002_A001);
    send_vector(vec(16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A));
    idle(2 * C);
    chk("b2b_strobes", avail_cnt - a0, 2);
    chk("v6_nums", bus.rx_nums, 80'h090A_0708_0506_0304_0102);
    chk("b2b_spacing", t_last - t_prev, 10 * BITS * C);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
